mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 28 ++
 rtl/btn_step.sv | 27 ++
 rtl/mem_responder.sv | 170 +++++++++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and the front-panel controller:
// cpustate mode encodings, CPU-side FSM states and common widths.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_LOAD  = 2'b01,
      MODE_CHECK = 2'b10,
      MODE_RUN   = 2'b11
   } cpu_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RD    = 2'b01,
      ST_RDONE = 2'b10,
      ST_WR    = 2'b11
   } cpu_fsm_t;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned ADDR_BUS_W  = 16;
   localparam int unsigned DATA_W      = 8;

   // Modes in which the manual pointer advances on a button step.
   function automatic logic mode_is_manual(input cpu_mode_t m);
      return (m == MODE_LOAD) || (m == MODE_CHECK);
   endfunction

endpackage

// File: rtl/btn_step.sv
// Manual step button: two-flop synchronizer followed by a rising-edge detector,
// so one press produces exactly one single-cycle step pulse.
module btn_step
   import mem_responder_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic step
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg <= '0;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign step = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory shared between a CPU bus (RUN mode, handshaked reads/writes)
// and a front panel that loads or inspects memory one button press at a time.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int AW = 8
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_BUS_W-1:0] addr,
   input  logic [DATA_W-1:0]     data_in,
   output logic [DATA_W-1:0]     data_out,
   output logic                  ready,
   output logic                  busy,
   input  logic [1:0]            cpustate,
   input  logic                  A1,
   input  logic [DATA_W-1:0]     D,
   output logic [DATA_W-1:0]     check_out,
   output logic [AW-1:0]         man_addr
);

   localparam int DEPTH = 1 << AW;

   logic [DATA_W-1:0] mem [DEPTH];

   cpu_fsm_t          state_reg;
   cpu_fsm_t          state_next;
   cpu_mode_t         mode;
   cpu_mode_t         mode_reg;
   logic              mode_changed;
   logic              step;
   logic              man_step;
   logic              man_wr;
   logic              man_adv;
   logic              cpu_wr;
   logic              leave_idle;
   logic [AW-1:0]     man_addr_reg;
   logic [AW-1:0]     cap_addr_reg;
   logic [DATA_W-1:0] cap_data_reg;
   logic [DATA_W-1:0] data_out_reg;
   logic [DATA_W-1:0] check_out_reg;

   assign mode         = cpu_mode_t'(cpustate);
   assign mode_changed = (mode != mode_reg);

   // Upper CPU address bits alias onto the decoded range.
   generate
      if (AW < ADDR_BUS_W) begin : g_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^addr[ADDR_BUS_W-1:AW];
      end
   endgenerate

   btn_step u_btn_step (
      .clk  (clk),
      .rst  (rst),
      .btn  (A1),
      .step (step)
   );

   // A step coinciding with a mode change is dropped along with the pointer clear.
   assign man_step = step & ~mode_changed;
   assign man_wr   = man_step & (mode == MODE_LOAD);
   assign man_adv  = man_step & mode_is_manual(mode);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_reg     <= MODE_HOLD;
         man_addr_reg <= '0;
      end else begin
         mode_reg <= mode;
         if (mode_changed) begin
            man_addr_reg <= '0;
         end else if (man_adv) begin
            man_addr_reg <= man_addr_reg + AW'(1);
         end
      end
   end

   // CPU FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // CPU FSM: next state; write has priority over read
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (mode == MODE_RUN) begin
               if (write) begin
                  state_next = ST_WR;
               end else if (read) begin
                  state_next = ST_RD;
               end
            end
         end
         ST_RD:    state_next = ST_RDONE;
         ST_RDONE: state_next = ST_IDLE;
         ST_WR:    state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // CPU FSM: outputs
   always_comb begin
      ready      = 1'b0;
      busy       = 1'b0;
      cpu_wr     = 1'b0;
      leave_idle = 1'b0;
      case (state_reg)
         ST_IDLE:  leave_idle = (state_next != ST_IDLE);
         ST_RD:    busy = 1'b1;
         ST_RDONE: begin
            busy  = 1'b1;
            ready = 1'b1;
         end
         ST_WR: begin
            busy   = 1'b1;
            ready  = 1'b1;
            cpu_wr = 1'b1;
         end
         default: ;
      endcase
   end

   // The access works from captured copies so the bus may change mid-access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_addr_reg <= '0;
         cap_data_reg <= '0;
      end else if (leave_idle) begin
         cap_addr_reg <= addr[AW-1:0];
         cap_data_reg <= data_in;
      end
   end

   // Memory array is never reset; CPU writes take priority over panel loads.
   always_ff @(posedge clk) begin
      if (cpu_wr) begin
         mem[cap_addr_reg] <= cap_data_reg;
      end else if (man_wr) begin
         mem[man_addr_reg] <= D;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_reg  <= '0;
         check_out_reg <= '0;
      end else begin
         if (state_reg == ST_RD) begin
            data_out_reg <= mem[cap_addr_reg];
         end
         check_out_reg <= mem[man_addr_reg];
      end
   end

   assign data_out  = data_out_reg;
   assign check_out = check_out_reg;
   assign man_addr  = man_addr_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: stimulus pushes expected read data into a
// scoreboard queue, and a negedge monitor pops and compares on every ready pulse.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        read;
   logic        write;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        ready;
   logic        busy;
   logic [1:0]  cpustate;
   logic        A1;
   logic [7:0]  D;
   logic [7:0]  check_out;
   logic [7:0]  man_addr;

   typedef struct {
      logic [7:0] data;
      string      name;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_exp;
   int         checks = 0;
   int         passes = 0;
   logic [7:0] model_mem [256];
   logic [7:0] last_rd = 8'h00;

   mem_responder #(.AW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .read      (read),
      .write     (write),
      .addr      (addr),
      .data_in   (data_in),
      .data_out  (data_out),
      .ready     (ready),
      .busy      (busy),
      .cpustate  (cpustate),
      .A1        (A1),
      .D         (D),
      .check_out (check_out),
      .man_addr  (man_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Monitor: every ready pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (rst === 1'b1 && ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_ready: got ready=1 data_out=0x%02h, want no response", data_out);
         end else begin
            mon_exp = sb.pop_front();
            $display("txn %s: data_out=0x%02h expected=0x%02h", mon_exp.name, data_out, mon_exp.data);
            check(mon_exp.name, {24'h0, data_out}, {24'h0, mon_exp.data});
         end
      end
   end

   // Drive a request; the expected data_out at ready is queued (writes leave it unchanged).
   task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [7:0] d, input string name);
      @(posedge clk); #1;
      read = rd; write = wr; addr = a; data_in = d;
      if (wr) model_mem[a[7:0]] = d;
      else    last_rd = model_mem[a[7:0]];
      sb.push_back('{data: last_rd, name: name});
   endtask

   // Wait past the request edge, scramble the bus, and time the ready pulse.
   task automatic await_ready(input int exp_lat, input string name);
      int lat = 0;
      bit seen = 1'b0;
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0; addr = 16'hFFFF; data_in = 8'hEE;
      while (!seen && lat < 10) begin
         @(negedge clk);
         lat++;
         check({name, "_busy"}, {31'h0, busy}, 32'd1);
         if (ready) seen = 1'b1;
      end
      check({name, "_latency"}, lat, exp_lat);
      @(negedge clk);
      check({name, "_ready_pulse"}, {31'h0, ready}, 32'd0);
      check({name, "_busy_done"}, {31'h0, busy}, 32'd0);
   endtask

   task automatic press();
      @(posedge clk); #1 A1 = 1'b1;
      repeat (4) @(posedge clk);
      #1 A1 = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nready;
      rst = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
      cpustate = 2'b00; A1 = 1'b0; D = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_data_out", {24'h0, data_out}, 32'h0);
      check("rst_ready", {31'h0, ready}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_check_out", {24'h0, check_out}, 32'h0);
      check("rst_man_addr", {24'h0, man_addr}, 32'h0);
      @(negedge clk) rst = 1'b1;

      // Manual load of two bytes
      @(posedge clk); #1 cpustate = 2'b01;
      repeat (2) @(posedge clk);
      D = 8'h3A; press(); model_mem[0] = 8'h3A;
      @(negedge clk) check("load_ptr1", {24'h0, man_addr}, 32'd1);
      D = 8'h5C; press(); model_mem[1] = 8'h5C;
      @(negedge clk) check("load_ptr2", {24'h0, man_addr}, 32'd2);

      // Read held in LOAD must be ignored, then completes once RUN is selected
      @(posedge clk); #1 read = 1'b1; addr = 16'h0000;
      nready = 0;
      repeat (10) begin
         @(negedge clk);
         if (ready) nready++;
      end
      check("gated_ready_count", nready, 0);
      @(posedge clk); #1 cpustate = 2'b11;
      last_rd = model_mem[0];
      sb.push_back('{data: last_rd, name: "gated_read"});
      await_ready(2, "gated_read");
      check("run_clears_ptr", {24'h0, man_addr}, 32'd0);

      issue(1'b1, 1'b0, 16'h0001, 8'h00, "read_a1");
      await_ready(2, "read_a1");

      issue(1'b1, 1'b1, 16'h0102, 8'h77, "rw_both_write");
      await_ready(1, "rw_both_write");
      issue(1'b1, 1'b0, 16'h0002, 8'h00, "read_after_write");
      await_ready(2, "read_after_write");

      // Held read request yields two back-to-back accesses
      issue(1'b1, 1'b0, 16'h0001, 8'h00, "b2b_read0");
      sb.push_back('{data: last_rd, name: "b2b_read1"});
      nready = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         if (i == 3) begin
            #1 read = 1'b0;
         end
         @(negedge clk);
         if (ready) nready++;
      end
      check("b2b_ready_count", nready, 2);

      D = 8'h99; press();
      @(negedge clk) check("run_step_ignored", {24'h0, man_addr}, 32'd0);

      issue(1'b0, 1'b1, 16'h0005, 8'hA5, "write_a5");
      await_ready(1, "write_a5");
      issue(1'b1, 1'b0, 16'h0005, 8'h00, "read_a5");
      await_ready(2, "read_a5");

      // Reset during RD
      issue(1'b1, 1'b0, 16'h0001, 8'h00, "aborted_read");
      @(posedge clk); #1 rst = 1'b0; read = 1'b0;
      sb.delete(); last_rd = 8'h00;
      #1;
      check("rd_abort_ready", {31'h0, ready}, 32'h0);
      check("rd_abort_busy", {31'h0, busy}, 32'h0);
      check("rd_abort_data_out", {24'h0, data_out}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Reset during WR must not write memory
      issue(1'b0, 1'b1, 16'h0005, 8'h11, "aborted_write");
      model_mem[5] = 8'hA5;
      @(posedge clk); #1 rst = 1'b0; write = 1'b0;
      sb.delete();
      #1 check("wr_abort_busy", {31'h0, busy}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      issue(1'b1, 1'b0, 16'h0005, 8'h00, "read_after_abort");
      await_ready(2, "read_after_abort");

      // CHECK mode pointer walk and wrap
      @(posedge clk); #1 cpustate = 2'b10; D = 8'hEE;
      repeat (255) press();
      @(negedge clk) check("check_ptr_ff", {24'h0, man_addr}, 32'hFF);
      press();
      @(negedge clk);
      check("check_ptr_wrap", {24'h0, man_addr}, 32'h0);
      check("check_out_mem0", {24'h0, check_out}, 32'h3A);

      @(posedge clk); #1 cpustate = 2'b11;
      issue(1'b1, 1'b0, 16'h0002, 8'h00, "read_after_check");
      await_ready(2, "read_after_check");

      repeat (3) @(posedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
